// File: rtl/in_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : in_port_unit
// Brief    : InPort receiver. Buffers externally pushed words and presents the
//            head word to the bus encoder while InPortout is high; one word is
//            consumed per InPortout pulse, on its falling edge. Build option
//            INPORT_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single
//            holding register is used.
// Revision : 1.0
// ============================================================================
module in_port_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        ext_data,
    input  logic                    ext_valid,
    output logic                    ext_ready,
    input  logic                    InPortout,
    input  logic                    status_clr,
    output logic [WIDTH-1:0]        InPort_data_out,
    output logic                    in_empty,
`ifdef INPORT_FIFO_EN
    output logic [$clog2(DEPTH):0]  in_count,
`else
    output logic [0:0]              in_count,
`endif
    output logic                    underflow
);

    logic inp_q;
    logic inp_d;
    logic underflow_q;
    logic underflow_d;
    logic push;
    logic pop;
    logic start;

    assign start = InPortout && !inp_q;
    assign pop   = !InPortout && inp_q && !in_empty;
    assign push  = ext_valid && ext_ready;

    // An empty start-of-access outranks a same-cycle status clear.
    always_comb begin
        inp_d       = InPortout;
        underflow_d = underflow_q;
        if (start && in_empty) begin
            underflow_d = 1'b1;
        end else if (status_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            inp_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            inp_q       <= inp_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;

`ifdef INPORT_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    assign ext_ready       = (count_q != FULL);
    assign in_empty        = (count_q == '0);
    assign in_count        = count_q;
    assign InPort_data_out = in_empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] hold_q;
    logic             full_q;
    logic             full_d;

    // Push only happens when empty and pop only when full, so they never coincide.
    always_comb begin
        full_d = full_q;
        if (push) begin
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            hold_q <= ext_data;
        end
    end

    assign in_empty        = !full_q;
    assign ext_ready       = in_empty;
    assign in_count        = full_q;
    assign InPort_data_out = full_q ? hold_q : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_in_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_port_unit
// Brief    : Self-checking bench for in_port_unit: queue-based reference model
//            compared every cycle, directed scenarios plus random traffic.
// Revision : 1.0
// ============================================================================
module tb_in_port_unit;

`ifdef INPORT_FIFO_EN
    localparam int CAP = 4;
    logic [2:0]  in_count;
`else
    localparam int CAP = 1;
    logic [0:0]  in_count;
`endif

    logic        Clock;
    logic        clear;
    logic [31:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic        InPortout;
    logic        status_clr;
    logic [31:0] InPort_data_out;
    logic        in_empty;
    logic        underflow;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];
    bit          m_prev = 1'b0;
    bit          m_uf   = 1'b0;

    in_port_unit #(.WIDTH(32), .DEPTH(4)) dut (
        .Clock           (Clock),
        .clear           (clear),
        .ext_data        (ext_data),
        .ext_valid       (ext_valid),
        .ext_ready       (ext_ready),
        .InPortout       (InPortout),
        .status_clr      (status_clr),
        .InPort_data_out (InPort_data_out),
        .in_empty        (in_empty),
        .in_count        (in_count),
        .underflow       (underflow)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of held words with capacity CAP.
    initial begin
        logic        s_v, s_io, s_sc, s_clr;
        logic [31:0] s_d;
        int          n0;
        forever begin
            @(posedge Clock);
            s_v = ext_valid; s_d = ext_data; s_io = InPortout;
            s_sc = status_clr; s_clr = clear;
            if (s_clr) begin
                mq.delete();
                m_prev = 1'b0;
                m_uf   = 1'b0;
            end else begin
                n0 = mq.size();
                if (s_io && !m_prev && n0 == 0) m_uf = 1'b1;
                else if (s_sc)                  m_uf = 1'b0;
                if (!s_io && m_prev && n0 != 0) void'(mq.pop_front());
                if (s_v && n0 < CAP)            mq.push_back(s_d);
                m_prev = s_io;
            end
            @(negedge Clock);
            chk("count",     32'(in_count),  32'(mq.size()));
            chk("empty",     32'(in_empty),  32'(mq.size() == 0));
            chk("ready",     32'(ext_ready), 32'(mq.size() < CAP));
            chk("data",      InPort_data_out, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("underflow", 32'(underflow), 32'(m_uf));
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic io, input logic sc);
        @(negedge Clock);
        #1;
        ext_valid  = v;
        ext_data   = d;
        InPortout  = io;
        status_clr = sc;
    endtask

    task automatic after_edge();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_head [4];
        exp_head[0] = 32'h11; exp_head[1] = 32'h22;
        exp_head[2] = 32'h33; exp_head[3] = 32'h44;

        clear = 1'b1; ext_valid = 1'b0; ext_data = '0; InPortout = 1'b0; status_clr = 1'b0;
        #1;
        chk("rst_count", 32'(in_count), 32'h0);
        chk("rst_empty", 32'(in_empty), 32'h1);
        chk("rst_ready", 32'(ext_ready), 32'h1);
        chk("rst_data",  InPort_data_out, 32'h0);
        chk("rst_uf",    32'(underflow), 32'h0);
        #11 clear = 1'b0;

        // asynchronous clear with words held
        drive(1'b1, 32'h1234, 1'b0, 1'b0);
        drive(1'b1, 32'h5678, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge Clock);
        #3 clear = 1'b1;
        #1;
        chk("aclr_count", 32'(in_count), 32'h0);
        chk("aclr_empty", 32'(in_empty), 32'h1);
        chk("aclr_ready", 32'(ext_ready), 32'h1);
        chk("aclr_data",  InPort_data_out, 32'h0);
        @(negedge Clock);
        #3 clear = 1'b0;

        // fill and order
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        after_edge();
        chk("full_count", 32'(in_count), 32'(CAP));
        chk("full_ready", 32'(ext_ready), 32'h0);
        chk("full_head",  InPort_data_out, 32'h11);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef INPORT_FIFO_EN
            chk("pulse_head", InPort_data_out, exp_head[i]);
`else
            chk("pulse_head", InPort_data_out, (i == 0) ? 32'h11 : 32'h0);
`endif
            drive(1'b0, 32'h0, 1'b0, 1'b0);
        end
        after_edge();
        chk("drain_empty", 32'(in_empty), 32'h1);

        // long assertion
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        drive(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("long_head", InPort_data_out, 32'hA5A5A5A5);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        after_edge();
        chk("long_next",  InPort_data_out, (CAP > 1) ? 32'h5A5A5A5A : 32'h0);
        chk("long_count", 32'(in_count), (CAP > 1) ? 32'h1 : 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // underflow
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        after_edge();
        chk("uf_set",   32'(underflow), 32'h1);
        chk("uf_count", 32'(in_count), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        after_edge();
        chk("uf_clr", 32'(underflow), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        after_edge();
        chk("uf_prio", 32'(underflow), 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // concurrent push and pop
        drive(1'b1, 32'h0000C0DE, 1'b0, 1'b0);
        drive(1'b1, 32'h0000F00D, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        after_edge();
        chk("conc_count", 32'(in_count), (CAP > 1) ? 32'h2 : 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 1'b0);
        end

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 1'b0);
        end

        // random traffic, including async clear mid-access
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
            clear = ($urandom_range(0, 59) == 0);
        end
        clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge Clock);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
